// File: rtl/snitch_fpga_mem_arbiter_if.sv
// Bus bundle for the memory arbiter: per-requester request/response lanes plus the
// shared memory port. The slave modport is the arbiter's view; master is the environment's.
interface snitch_fpga_mem_arbiter_if #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned MemAW    = 10,
  parameter int unsigned MemDW    = 32
);
  localparam int unsigned StrbWidth = MemDW / 8;

  logic [NumPorts-1:0][MemAW-1:0]     port_req_addr_i;
  logic [NumPorts-1:0][MemDW-1:0]     port_req_data_i;
  logic [NumPorts-1:0]                port_req_write_i;
  logic [NumPorts-1:0][StrbWidth-1:0] port_req_wstrb_i;
  logic [NumPorts-1:0]                port_req_valid_i;
  logic [NumPorts-1:0]                port_req_ready_o;
  logic [NumPorts-1:0][MemDW-1:0]     port_rsp_data_o;
  logic [NumPorts-1:0]                port_rsp_valid_o;
  logic [NumPorts-1:0]                port_rsp_ready_i;

  logic [MemAW-1:0]     mem_req_addr_o;
  logic [MemDW-1:0]     mem_req_data_o;
  logic                 mem_req_write_o;
  logic [StrbWidth-1:0] mem_req_wstrb_o;
  logic                 mem_req_valid_o;
  logic                 mem_req_ready_i;
  logic [MemDW-1:0]     mem_rsp_data_i;
  logic                 mem_rsp_valid_i;
  logic                 mem_rsp_ready_o;

  modport slave (
    input  port_req_addr_i, port_req_data_i, port_req_write_i, port_req_wstrb_i,
    input  port_req_valid_i, port_rsp_ready_i,
    output port_req_ready_o, port_rsp_data_o, port_rsp_valid_o,
    output mem_req_addr_o, mem_req_data_o, mem_req_write_o, mem_req_wstrb_o, mem_req_valid_o,
    input  mem_req_ready_i, mem_rsp_data_i, mem_rsp_valid_i,
    output mem_rsp_ready_o
  );

  modport master (
    output port_req_addr_i, port_req_data_i, port_req_write_i, port_req_wstrb_i,
    output port_req_valid_i, port_rsp_ready_i,
    input  port_req_ready_o, port_rsp_data_o, port_rsp_valid_o,
    input  mem_req_addr_o, mem_req_data_o, mem_req_write_o, mem_req_wstrb_o, mem_req_valid_o,
    output mem_req_ready_i, mem_rsp_data_i, mem_rsp_valid_i,
    input  mem_rsp_ready_o
  );
endinterface

// File: rtl/snitch_fpga_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among several requesters; an in-order
// tag FIFO remembers who issued each request so responses return to their owner.
module snitch_fpga_mem_arbiter #(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned MemAW          = 10,
  parameter int unsigned MemDW          = 32,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned StrbWidth     = MemDW / 8,
  localparam int unsigned IdxW          = $clog2(NumPorts),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  snitch_fpga_mem_arbiter_if.slave bus,
  output logic [CntW-1:0]     outstanding_o,
  output logic                err_o
);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0] rr_q, lock_idx_q, arb_idx, grant_idx, cand_idx, head;
  logic            lock_q, arb_found, any_req, full, empty, req_hs, rsp_hs;
  logic [MaxOutstanding-1:0][IdxW-1:0] tags_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  int unsigned     cand;

  // First valid requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NumPorts) cand = cand - NumPorts;
      cand_idx = IdxW'(cand);
      if (!arb_found && bus.port_req_valid_i[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign grant_idx = lock_q ? lock_idx_q : arb_idx;
  assign any_req   = (|bus.port_req_valid_i) | lock_q;
  assign full      = (cnt_q == CntW'(MaxOutstanding));
  assign empty     = (cnt_q == '0);

  assign bus.mem_req_valid_o = any_req & ~full;
  assign bus.mem_req_addr_o  = bus.port_req_addr_i[grant_idx];
  assign bus.mem_req_data_o  = bus.port_req_data_i[grant_idx];
  assign bus.mem_req_write_o = bus.port_req_write_i[grant_idx];
  assign bus.mem_req_wstrb_o = bus.port_req_wstrb_i[grant_idx];
  assign req_hs = bus.mem_req_valid_o & bus.mem_req_ready_i;

  always_comb begin
    bus.port_req_ready_o = '0;
    if (any_req && !full) bus.port_req_ready_o[grant_idx] = bus.mem_req_ready_i;
  end

  // Responses come back in order, so the FIFO head always names the owner.
  assign head = tags_q[rd_ptr_q];
  assign bus.mem_rsp_ready_o = bus.port_rsp_ready_i[head] & ~empty;
  assign rsp_hs = bus.mem_rsp_valid_i & bus.mem_rsp_ready_o;

  always_comb begin
    bus.port_rsp_valid_o = '0;
    bus.port_rsp_valid_o[head] = bus.mem_rsp_valid_i & ~empty;
    for (int unsigned p = 0; p < NumPorts; p++) bus.port_rsp_data_o[p] = bus.mem_rsp_data_i;
  end

  // A stalled request keeps its grant so the memory sees stable fields until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (req_hs) begin
      rr_q   <= (grant_idx == IdxW'(NumPorts - 1)) ? '0 : grant_idx + IdxW'(1);
      lock_q <= 1'b0;
    end else if (bus.mem_req_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (req_hs) begin
        tags_q[wr_ptr_q] <= grant_idx;
        wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (rsp_hs) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({req_hs, rsp_hs})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      // A response with nothing outstanding is a protocol violation; latch it.
      if (bus.mem_rsp_valid_i && empty) err_q <= 1'b1;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_snitch_fpga_mem_arbiter.sv
// Directed bench for snitch_fpga_mem_arbiter: arbitration, grant lock, full FIFO,
// response routing/backpressure and the sticky error flag.
module tb_snitch_fpga_mem_arbiter;
  localparam int unsigned NumPorts = 2;
  localparam int unsigned MemAW    = 10;
  localparam int unsigned MemDW    = 32;
  localparam int unsigned MaxOut   = 2;
  localparam int unsigned CntW     = $clog2(MaxOut + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [CntW-1:0] outstanding_o;
  logic            err_o;
  int              total_cnt = 0;
  int              pass_cnt  = 0;

  snitch_fpga_mem_arbiter_if #(.NumPorts(NumPorts), .MemAW(MemAW), .MemDW(MemDW)) bus ();

  snitch_fpga_mem_arbiter #(
    .NumPorts(NumPorts), .MemAW(MemAW), .MemDW(MemDW), .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Drive one cycle's worth of inputs and let the combinational paths settle.
  task automatic applyStimulus(input logic [1:0] valid, input logic [MemAW-1:0] a0,
                               input logic [MemAW-1:0] a1, input logic mem_ready,
                               input logic rsp_valid, input logic [MemDW-1:0] rsp_data,
                               input logic [1:0] rsp_ready);
    bus.port_req_valid_i   = valid;
    bus.port_req_addr_i[0] = a0;
    bus.port_req_addr_i[1] = a1;
    bus.mem_req_ready_i    = mem_ready;
    bus.mem_rsp_valid_i    = rsp_valid;
    bus.mem_rsp_data_i     = rsp_data;
    bus.port_rsp_ready_i   = rsp_ready;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00);
    rst_ni = 1'b0;
    stepClock();
    stepClock();
    rst_ni = 1'b1;
    stepClock();
  endtask

  initial begin
    bus.port_req_data_i[0]  = 32'h1111_0000;
    bus.port_req_data_i[1]  = 32'h2222_0000;
    bus.port_req_write_i    = 2'b10;
    bus.port_req_wstrb_i[0] = 4'hF;
    bus.port_req_wstrb_i[1] = 4'h3;
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00);
    stepClock();

    // Outputs held in reset
    checkOutput("rst_mem_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
    checkOutput("rst_port_req_ready", 64'(bus.port_req_ready_o), 64'd0);
    checkOutput("rst_port_rsp_valid", 64'(bus.port_rsp_valid_o), 64'd0);
    checkOutput("rst_mem_rsp_ready", 64'(bus.mem_rsp_ready_o), 64'd0);
    checkOutput("rst_outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);
    rst_ni = 1'b1;
    stepClock();

    // Single read from port 0
    applyStimulus(2'b01, 10'h010, 10'h000, 1'b1, 1'b0, '0, 2'b11);
    checkOutput("t1_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
    checkOutput("t1_req_addr", 64'(bus.mem_req_addr_o), 64'h010);
    checkOutput("t1_req_data", 64'(bus.mem_req_data_o), 64'h1111_0000);
    checkOutput("t1_req_ready", 64'(bus.port_req_ready_o), 64'b01);
    stepClock();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    checkOutput("t1_outstanding1", 64'(outstanding_o), 64'd1);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b11);
    checkOutput("t1_rsp_valid", 64'(bus.port_rsp_valid_o), 64'b01);
    checkOutput("t1_rsp_data", 64'(bus.port_rsp_data_o[0]), 64'hDEAD_BEEF);
    checkOutput("t1_mem_rsp_ready", 64'(bus.mem_rsp_ready_o), 64'd1);
    stepClock();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    checkOutput("t1_outstanding0", 64'(outstanding_o), 64'd0);

    // Contention: grants alternate, responses follow the issue order
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 10'h100, 10'h200, 1'b1, (k > 0), 32'hA0 + k, 2'b11);
      checkOutput($sformatf("t2_grant_ready_%0d", k), 64'(bus.port_req_ready_o),
                  (k % 2 == 0) ? 64'b01 : 64'b10);
      checkOutput($sformatf("t2_grant_addr_%0d", k), 64'(bus.mem_req_addr_o),
                  (k % 2 == 0) ? 64'h100 : 64'h200);
      if (k > 0)
        checkOutput($sformatf("t2_rsp_route_%0d", k), 64'(bus.port_rsp_valid_o),
                    ((k - 1) % 2 == 0) ? 64'b01 : 64'b10);
      stepClock();
    end
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 32'hA4, 2'b11);
    checkOutput("t2_rsp_route_last", 64'(bus.port_rsp_valid_o), 64'b10);
    stepClock();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    checkOutput("t2_outstanding", 64'(outstanding_o), 64'd0);

    // Grant lock: port 1 stalled, port 0 arrives with the pointer favouring it
    resetDut();
    applyStimulus(2'b10, 10'h0B0, 10'h2A0, 1'b0, 1'b0, '0, 2'b11);
    checkOutput("t3_lock_valid", 64'(bus.mem_req_valid_o), 64'd1);
    checkOutput("t3_lock_ready0", 64'(bus.port_req_ready_o), 64'b00);
    stepClock();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b11, 10'h0B0, 10'h2A0, 1'b0, 1'b0, '0, 2'b11);
      checkOutput($sformatf("t3_lock_addr_%0d", k), 64'(bus.mem_req_addr_o), 64'h2A0);
      checkOutput($sformatf("t3_lock_ready_%0d", k), 64'(bus.port_req_ready_o), 64'b00);
      stepClock();
    end
    applyStimulus(2'b11, 10'h0B0, 10'h2A0, 1'b1, 1'b0, '0, 2'b11);
    checkOutput("t3_accept_addr", 64'(bus.mem_req_addr_o), 64'h2A0);
    checkOutput("t3_accept_ready", 64'(bus.port_req_ready_o), 64'b10);
    stepClock();
    applyStimulus(2'b01, 10'h0B0, 10'h2A0, 1'b1, 1'b0, '0, 2'b11);
    checkOutput("t3_next_addr", 64'(bus.mem_req_addr_o), 64'h0B0);
    checkOutput("t3_next_ready", 64'(bus.port_req_ready_o), 64'b01);
    stepClock();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    checkOutput("t3_outstanding", 64'(outstanding_o), 64'd2);
    // Reset mid-transaction drops in-flight tags immediately
    rst_ni = 1'b0;
    #1;
    checkOutput("t3_async_reset", 64'(outstanding_o), 64'd0);
    rst_ni = 1'b1;
    stepClock();

    // Full FIFO blocks requests; pop then push keeps occupancy bounded
    resetDut();
    applyStimulus(2'b11, 10'h011, 10'h022, 1'b1, 1'b0, '0, 2'b11);
    stepClock();
    stepClock();
    applyStimulus(2'b01, 10'h033, 10'h022, 1'b1, 1'b0, '0, 2'b11);
    checkOutput("t4_full_count", 64'(outstanding_o), 64'd2);
    checkOutput("t4_full_ready", 64'(bus.port_req_ready_o), 64'b00);
    checkOutput("t4_full_valid", 64'(bus.mem_req_valid_o), 64'd0);
    applyStimulus(2'b01, 10'h033, 10'h022, 1'b1, 1'b1, 32'h55, 2'b11);
    checkOutput("t4_pop_route0", 64'(bus.port_rsp_valid_o), 64'b01);
    checkOutput("t4_pop_no_req", 64'(bus.mem_req_valid_o), 64'd0);
    stepClock();
    applyStimulus(2'b01, 10'h033, 10'h022, 1'b1, 1'b1, 32'h66, 2'b11);
    checkOutput("t4_after_pop", 64'(outstanding_o), 64'd1);
    checkOutput("t4_push_pop_ready", 64'(bus.port_req_ready_o), 64'b01);
    checkOutput("t4_pop_route1", 64'(bus.port_rsp_valid_o), 64'b10);
    stepClock();
    applyStimulus(2'b01, 10'h044, 10'h022, 1'b1, 1'b0, '0, 2'b11);
    checkOutput("t4_push_pop_count", 64'(outstanding_o), 64'd1);
    stepClock();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    checkOutput("t4_refull_count", 64'(outstanding_o), 64'd2);

    // Response backpressure on head port 1
    resetDut();
    applyStimulus(2'b10, 10'h000, 10'h155, 1'b1, 1'b0, '0, 2'b11);
    stepClock();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1, 32'h77, 2'b01);
    checkOutput("t5_bp_mem_ready", 64'(bus.mem_rsp_ready_o), 64'd0);
    checkOutput("t5_bp_route", 64'(bus.port_rsp_valid_o), 64'b10);
    stepClock();
    checkOutput("t5_bp_no_pop", 64'(outstanding_o), 64'd1);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1, 32'h77, 2'b11);
    checkOutput("t5_release_ready", 64'(bus.mem_rsp_ready_o), 64'd1);
    stepClock();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    checkOutput("t5_popped", 64'(outstanding_o), 64'd0);

    // Spurious response with nothing outstanding
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1, 32'h99, 2'b11);
    checkOutput("t6_spur_ready", 64'(bus.mem_rsp_ready_o), 64'd0);
    checkOutput("t6_spur_route", 64'(bus.port_rsp_valid_o), 64'b00);
    checkOutput("t6_err_before", 64'(err_o), 64'd0);
    stepClock();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b11);
    checkOutput("t6_err_set", 64'(err_o), 64'd1);
    stepClock();
    stepClock();
    checkOutput("t6_err_sticky", 64'(err_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_err_cleared", 64'(err_o), 64'd0);
    rst_ni = 1'b1;
    stepClock();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
